// File: rtl/tone_gen.sv
// tone_gen: glitch-free square-wave tone generator, pitch changes only at half-period boundaries
module tone_gen #(
  parameter int TICK_DIV = 1040
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [6:0] scale,
  output logic       speaker,
  output logic       note_active,
  output logic       note_start
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  logic [PW-1:0] pre_cnt;
  logic [6:0] hp_cnt, cur_scale;
  logic play, tick, bnd;
  always_comb begin
    play = cur_scale != 7'd0;
    tick = play && pre_cnt == PMAX;
    bnd = tick && hp_cnt == cur_scale - 7'd1;
  end
  assign note_active = play;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pre_cnt <= '0;
      hp_cnt <= '0;
      cur_scale <= '0;
      speaker <= 1'b0;
      note_start <= 1'b0;
    end else if (!enable) begin
      pre_cnt <= '0;
      hp_cnt <= '0;
      cur_scale <= '0;
      speaker <= 1'b0;
      note_start <= 1'b0;
    end else if (!play) begin
      pre_cnt <= '0;
      hp_cnt <= '0;
      cur_scale <= scale;
      speaker <= scale != 7'd0;
      note_start <= scale != 7'd0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      hp_cnt <= bnd ? 7'd0 : tick ? hp_cnt + 7'd1 : hp_cnt;
      note_start <= bnd && scale != 7'd0 && scale != cur_scale;
      // a zero scale on the boundary mutes instead of toggling
      if (bnd) begin
        cur_scale <= scale;
        speaker <= scale != 7'd0 && !speaker;
      end
    end
endmodule
